// File: rtl/dmem_be_if.sv
// Request/response bundle between the core's memory stage (master) and dmem_be (slave).
interface dmem_be_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     daddr;
  logic [DATA_W-1:0]     indata;
  logic [DATA_W-1:0]     outdata;
  logic                  rvalid;
  logic                  err;
  logic                  ready;

  modport master (
    output req, we, be, daddr, indata,
    input  outdata, rvalid, err, ready
  );

  modport slave (
    input  req, we, be, daddr, indata,
    output outdata, rvalid, err, ready
  );
endinterface

// File: rtl/dmem_be.sv
// Byte-enabled data memory with registered read port, address error flag and post-reset
// zero-fill of the whole array before requests are accepted.
module dmem_be #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  dmem_be_if.slave bus
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    init_idx_q;
  logic [DATA_W-1:0]   outdata_q;
  logic                rvalid_q;
  logic                err_q;
  logic                ready_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                legal;
  logic                accept;
  logic [IDX_W-1:0]    idx;
  logic [NB-1:0]       wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [DATA_W-1:0]   wr_data;

  always_comb begin
    idx    = IDX_W'(bus.daddr >> OFF_W);
    legal  = ((bus.daddr & ADDR_W'(NB - 1)) == '0) &&
             ((bus.daddr >> (OFF_W + IDX_W)) == '0);
    accept = bus.req && (state_q == StRun);
    // The single write port is shared between the zero-fill and accepted stores.
    if (state_q == StInit) begin
      wr_en   = '1;
      wr_idx  = init_idx_q;
      wr_data = '0;
    end else begin
      wr_en   = (accept && bus.we && legal) ? bus.be : '0;
      wr_idx  = idx;
      wr_data = bus.indata;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < int'(NB); k++) begin
      if (wr_en[k]) begin
        mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StInit;
      init_idx_q <= '0;
      outdata_q  <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        StInit: begin
          init_idx_q <= init_idx_q + IDX_W'(1);
          if (init_idx_q == IDX_W'(DEPTH - 1)) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          if (bus.req) begin
            err_q <= !legal;
            if (!bus.we) begin
              rvalid_q  <= 1'b1;
              outdata_q <= legal ? mem[idx] : '0;
            end
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign bus.outdata = outdata_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.err     = err_q;
  assign bus.ready   = ready_q;
endmodule

// File: doc/dmem_be.md
# dmem_be

Parametrised, byte-enabled data memory that replaces the fixed 1024×32 DMEM used by the datapath's load/store stage. It adds the following over DMEM:
- per-byte write strobes;
- a registered read port with a valid flag;
- an error flag for misaligned or out-of-range addresses;
- a hardware zero-fill sequence after reset.

It sits between the core's memory stage and the testbench/loader, keeping DMEM's byte-addressed `daddr` convention (word i at `daddr = 4*i` for 32-bit data).

## Interface

**Parameters**
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words; must be a power of two, ≥ 2.
- ADDR_W, 32, byte-address width of `daddr`.

**Ports**
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  1  access request, sampled on the rising edge.
- we  in  1  1 = write, 0 = read; qualified by req.
- be  in  DATA_W/8  byte write enables, bit k → `indata[8k+7:8k]`; ignored on reads.
- daddr  in  ADDR_W  byte address.
- indata  in  DATA_W  write data.
- outdata  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle pulse: `outdata` holds a completed read.
- err  out  1  one-cycle pulse: the previous accepted request was illegal.
- ready  out  1  1 when requests are accepted (zero-fill done).

## Operation

**Derived constants**
- OFF_W = clog2(DATA_W/8).
- IDX_W = clog2(DEPTH).
- Word index = `daddr[OFF_W+IDX_W-1:OFF_W]`.

**Legality.** A request is legal iff both hold:
- `daddr[OFF_W-1:0] == 0`;
- `daddr[ADDR_W-1:OFF_W+IDX_W] == 0` (address < DEPTH·DATA_W/8).

**FSM: INIT, RUN.**
- INIT:
  - entered asynchronously on reset;
  - a counter `init_idx` starts at 0 after rst_n deasserts and writes 0 to `mem[init_idx]` each cycle;
  - on the cycle `init_idx == DEPTH-1` is written, the FSM moves to RUN;
  - `ready` = 0 throughout INIT;
  - `req` is ignored: no write, no rvalid, no err.
- RUN: `ready` = 1; requests are accepted every cycle with no back-pressure.

**Accepted request** (`req` & `ready` on a rising edge):
- Legal write: for each k with `be[k]`=1, write byte k of `indata` into the indexed word; bytes with `be[k]`=0 are unchanged. `be` = 0 is a legal no-op write. No rvalid, no err.
- Legal read: next edge, `outdata` ← `mem[idx]` and `rvalid` = 1 for one cycle.
- Illegal request (read or write): no memory change. Next edge `err` = 1 for one cycle. For a read, `rvalid` = 1 and `outdata` = 0.
- Non-read cycles: `outdata` holds its last value.

**Other rules**
- Back-to-back accesses: a read in the cycle after a write to the same word returns the new data, because the write completes at the edge before the read is sampled.
- Reset mid-operation: the FSM returns to INIT and all outputs go to reset values immediately; any write on that edge is dropped; the full zero-fill reruns.

## Timing

**Reset values:** `outdata` = 0, `rvalid` = 0, `err` = 0, `ready` = 0, FSM = INIT, `init_idx` = 0.

**Zero-fill:** `ready` rises exactly DEPTH rising edges after rst_n deasserts; the first request is accepted on the edge after that.

**Latency**
- Read: 1 cycle. Request sampled at edge N; `outdata`/`rvalid` valid after edge N+1 and removed after edge N+2 unless another read follows.
- Write: visible to a read sampled at edge N+1.
- Err: asserted after edge N+1 for exactly one cycle.

**Throughput:** one request per cycle. Consecutive reads give consecutive rvalid pulses.

**Memory array:** not reset by rst_n except through the zero-fill; synthesisable as block RAM.

## Test plan

- Post-reset fill:
  - DEPTH=16: release rst_n → `ready` = 0 for 16 cycles, then 1.
  - Read every word → each returns 0x00000000 with `rvalid` pulses.
- Write/read sweep:
  - DEPTH=1024: for i = 0..1023, write pattern[i] at `daddr` = 4i with `be` = 4'hF, then read it → `outdata` == pattern[i] one cycle later.
  - Bench counts pass/fail and reports a total.
- Byte enables:
  - Write 0xAABBCCDD at 0x10 with `be` = F, then 0x11223344 with `be` = 4'b0101 → read 0x10 returns 0xAA22CC44.
  - Write with `be` = 0 → word unchanged.
- Illegal addresses:
  - Read 0x002 → `err` and `rvalid` pulse, `outdata` = 0.
  - Write 0x1000 with DEPTH=1024 → `err` pulse; a subsequent read of 0x000 is unchanged.
- Back-to-back:
  - Write 0x5A5A5A5A at 0x20, then read 0x20 on the very next cycle → 0x5A5A5A5A.
  - Three consecutive reads of 0x0, 0x4, 0x8 → three consecutive rvalid cycles in order.
- Reset mid-operation:
  - Assert rst_n low during a write to 0x40 → outputs 0 immediately; after refill, 0x40 reads 0.
  - `req` during INIT → no rvalid, no err.
